// File: rtl/spi_readout_responder_pkg.sv
// Shared types and widths for the readout SPI responder.
// FSM encoding is fixed so it can be matched in waveforms and firmware.
package spi_readout_responder_pkg;

  localparam int CMD_FIFO_WIDTH = 32;
  localparam int HIT_WORD_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/spi_readout_responder_if.sv
// SPI pin bundle between the readout initiator and the responder.
// master = initiator side, slave = chip-side responder.
interface spi_readout_responder_if;

  logic spi_csb;
  logic spi_clock;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_csb,
    output spi_clock,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_csb,
    input  spi_clock,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous SPI pin.
// rise/fall are single-cycle pulses derived from the synchronised level.
module spi_input_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic hist;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      hist  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      hist  <= level;
    end
  end

  assign rise = level & ~hist;
  assign fall = ~level & hist;

endmodule

// File: rtl/spi_readout_responder.sv
// Chip-side readout SPI responder: serves hit words on MISO, captures MOSI.
// Define SPI_RESPONDER_STATS_EN to add frame_count/underrun_count outputs.
module spi_readout_responder
  import spi_readout_responder_pkg::*;
#(
  parameter bit                          CPOL      = 1'b0,
  parameter bit                          CPHA      = 1'b1,
  parameter logic [HIT_WORD_WIDTH-1:0]   IDLE_WORD = '0,
  parameter int                          CMD_BITS  = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  spi_readout_responder_if.slave      spi,
  input  logic [HIT_WORD_WIDTH-1:0]   hit_fifo_data,
  input  logic                        hit_fifo_empty,
  output logic                        hit_fifo_rd_en,
  output logic [CMD_FIFO_WIDTH-1:0]   cmd_fifo_data,
  output logic                        cmd_fifo_wr_en,
  input  logic                        cmd_fifo_full,
  output logic                        busy,
  output logic                        underrun,
  output logic                        cmd_overflow
`ifdef SPI_RESPONDER_STATS_EN
  ,
  output logic [31:0]                 frame_count,
  output logic [15:0]                 underrun_count
`endif
);

  logic csb_level, csb_rise, csb_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync u_csb (
    .clock (clock),
    .reset (reset),
    .din   (spi.spi_csb),
    .level (csb_level),
    .rise  (csb_rise),
    .fall  (csb_fall)
  );

  spi_input_sync u_sck (
    .clock (clock),
    .reset (reset),
    .din   (spi.spi_clock),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_input_sync u_mosi (
    .clock (clock),
    .reset (reset),
    .din   (spi.spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_t                      state;
  logic [HIT_WORD_WIDTH-1:0]   shift_out;
  logic [HIT_WORD_WIDTH-1:0]   load_word;
  logic [CMD_BITS-1:0]         cmd;
  logic [CMD_BITS-1:0]         cmd_next;
  logic [7:0]                  bit_count;
  logic                        miso_r;
  logic                        lead, trail;
  logic                        shift_ev, sample_ev;

  assign lead      = CPOL ? sck_fall : sck_rise;
  assign trail     = CPOL ? sck_rise : sck_fall;
  assign shift_ev  = CPHA ? lead : trail;
  assign sample_ev = CPHA ? trail : lead;

  assign load_word = hit_fifo_empty ? IDLE_WORD : hit_fifo_data;
  assign cmd_next  = (cmd << 1) | CMD_BITS'(mosi_level);

  assign spi.spi_miso = miso_r;

  // Zeros shift in behind the word, so MISO falls to 0 after bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_WAIT_HIGH;
      shift_out      <= '0;
      cmd            <= '0;
      bit_count      <= '0;
      miso_r         <= 1'b0;
      hit_fifo_rd_en <= 1'b0;
      cmd_fifo_wr_en <= 1'b0;
      cmd_fifo_data  <= '0;
      busy           <= 1'b0;
      underrun       <= 1'b0;
      cmd_overflow   <= 1'b0;
    end else begin
      hit_fifo_rd_en <= 1'b0;
      cmd_fifo_wr_en <= 1'b0;
      unique case (state)
        ST_WAIT_HIGH: begin
          if (csb_level) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (csb_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          hit_fifo_rd_en <= ~hit_fifo_empty;
          if (hit_fifo_empty) underrun <= 1'b1;
          bit_count <= '0;
          cmd       <= '0;
          busy      <= 1'b1;
          if (CPHA) begin
            shift_out <= load_word;
          end else begin
            miso_r    <= load_word[HIT_WORD_WIDTH-1];
            shift_out <= {load_word[HIT_WORD_WIDTH-2:0], 1'b0};
          end
          state <= csb_rise ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (csb_rise) begin
            state <= ST_DONE;
          end else begin
            if (shift_ev) {miso_r, shift_out} <= {shift_out, 1'b0};
            if (sample_ev) begin
              cmd <= cmd_next;
              if (bit_count != 8'hFF) bit_count <= bit_count + 8'd1;
            end
          end
        end
        ST_DONE: begin
          busy   <= 1'b0;
          miso_r <= 1'b0;
          if (bit_count != 8'd0) begin
            cmd_fifo_data <= {bit_count, 24'(cmd)};
            if (cmd_fifo_full) cmd_overflow   <= 1'b1;
            else               cmd_fifo_wr_en <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_WAIT_HIGH;
      endcase
    end
  end

`ifdef SPI_RESPONDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count    <= '0;
      underrun_count <= '0;
    end else begin
      if (state == ST_DONE)
        frame_count <= frame_count + 32'd1;
      if (state == ST_LOAD && hit_fifo_empty)
        underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_readout_responder.sv
// Scoreboard bench for spi_readout_responder (CPOL=0, CPHA=1).
// Expected MISO bits and command words are queued; monitors pop them.
module tb_spi_readout_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] hit_fifo_data;
  logic        hit_fifo_empty;
  logic        hit_fifo_rd_en;
  logic [31:0] cmd_fifo_data;
  logic        cmd_fifo_wr_en;
  logic        cmd_fifo_full;
  logic        busy;
  logic        underrun;
  logic        cmd_overflow;
`ifdef SPI_RESPONDER_STATS_EN
  logic [31:0] frame_count;
  logic [15:0] underrun_count;
`endif

  spi_readout_responder_if spi ();

  spi_readout_responder dut (
    .clock          (clock),
    .reset          (reset),
    .spi            (spi.slave),
    .hit_fifo_data  (hit_fifo_data),
    .hit_fifo_empty (hit_fifo_empty),
    .hit_fifo_rd_en (hit_fifo_rd_en),
    .cmd_fifo_data  (cmd_fifo_data),
    .cmd_fifo_wr_en (cmd_fifo_wr_en),
    .cmd_fifo_full  (cmd_fifo_full),
    .busy           (busy),
    .underrun       (underrun),
    .cmd_overflow   (cmd_overflow)
`ifdef SPI_RESPONDER_STATS_EN
    ,
    .frame_count    (frame_count),
    .underrun_count (underrun_count)
`endif
  );

  always #5 clock = ~clock;

  int          applied = 0;
  int          miscompares = 0;
  int          rd_cnt = 0;
  logic        miso_q[$];
  logic [31:0] cmd_q[$];
  logic        exp_bit;
  logic [31:0] exp_cmd;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge spi.spi_clock) begin
    if (miso_q.size() > 0) begin
      exp_bit = miso_q.pop_front();
      check("miso_bit", 64'(spi.spi_miso), 64'(exp_bit));
    end
  end

  always @(negedge clock) begin
    if (hit_fifo_rd_en) rd_cnt++;
    if (cmd_fifo_wr_en) begin
      if (cmd_q.size() == 0) begin
        check("cmd_push_unexpected", 64'(cmd_fifo_wr_en), 64'd0);
      end else begin
        exp_cmd = cmd_q.pop_front();
        check("cmd_data", 64'(cmd_fifo_data), 64'(exp_cmd));
      end
    end
  end

  task automatic sck_run(input int first, input int n,
                         input logic [63:0] mo, input logic [63:0] mi);
    for (int i = first; i < first + n; i++) begin
      miso_q.push_back(mi[63-i]);
      spi.spi_mosi  = mo[63-i];
      spi.spi_clock = 1'b1;
      clk_wait(8);
      spi.spi_clock = 1'b0;
      clk_wait(8);
    end
  endtask

  task automatic frame(input string name, input logic [63:0] head,
                       input bit empty, input bit full, input int n,
                       input logic [63:0] mo, input bit exp_push,
                       input logic [31:0] exp_word);
    int rd0;
    hit_fifo_data  = head;
    hit_fifo_empty = empty;
    cmd_fifo_full  = full;
    if (exp_push) cmd_q.push_back(exp_word);
    rd0 = rd_cnt;
    spi.spi_csb = 1'b0;
    clk_wait(8);
    check({name, "_busy_hi"}, 64'(busy), 64'd1);
    sck_run(0, n, mo, empty ? 64'h0 : head);
    spi.spi_csb = 1'b1;
    clk_wait(8);
    check({name, "_busy_lo"}, 64'(busy), 64'd0);
    check({name, "_rd_pulses"}, 64'(rd_cnt - rd0), empty ? 64'd0 : 64'd1);
    check({name, "_cmd_pending"}, 64'(cmd_q.size()), 64'd0);
    check({name, "_miso_pending"}, 64'(miso_q.size()), 64'd0);
    cmd_fifo_full = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    reset          = 1'b1;
    spi.spi_csb    = 1'b1;
    spi.spi_clock  = 1'b0;
    spi.spi_mosi   = 1'b0;
    hit_fifo_data  = '0;
    hit_fifo_empty = 1'b1;
    cmd_fifo_full  = 1'b0;
    clk_wait(4);
    check("rst_miso", 64'(spi.spi_miso), 64'd0);
    check("rst_rd_en", 64'(hit_fifo_rd_en), 64'd0);
    check("rst_wr_en", 64'(cmd_fifo_wr_en), 64'd0);
    check("rst_cmd_data", 64'(cmd_fifo_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_overflow", 64'(cmd_overflow), 64'd0);
    reset = 1'b0;
    clk_wait(8);

    frame("full_word", 64'hDEADBEEF_01234567, 0, 0, 64,
          64'h0000_0000_00A5_C3F0, 1, 32'h40A5_C3F0);
    check("underrun_clear", 64'(underrun), 64'd0);

    frame("empty_fifo", 64'h1111_2222_3333_4444, 1, 0, 64,
          64'h0, 1, 32'h4000_0000);
    check("underrun_set", 64'(underrun), 64'd1);

    frame("after_empty", 64'h0F0F_0F0F_F0F0_F0F0, 0, 0, 64,
          64'hFFFF_FFFF_FFFF_FFFF, 1, 32'h40FF_FFFF);
    check("underrun_sticky", 64'(underrun), 64'd1);

    frame("short10", 64'hCAFEF00D_12345678, 0, 0, 10,
          64'hFFC0_0000_0000_0000, 1, 32'h0A00_03FF);
    frame("after_short", 64'h8000_0000_0000_0001, 0, 0, 64,
          64'hAAAA_AAAA_AAAA_AAAA, 1, 32'h40AA_AAAA);

    check("overflow_clear", 64'(cmd_overflow), 64'd0);
    frame("cmd_full", 64'h0123_4567_89AB_CDEF, 0, 1, 64,
          64'h0000_0000_0012_3456, 0, 32'h0);
    check("overflow_set", 64'(cmd_overflow), 64'd1);

    hit_fifo_data  = 64'h5A5A_5A5A_C3C3_C3C3;
    hit_fifo_empty = 1'b0;
    rd0 = rd_cnt;
    spi.spi_csb = 1'b0;
    clk_wait(8);
    sck_run(0, 20, 64'h0, 64'h5A5A_5A5A_C3C3_C3C3);
    reset = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    clk_wait(1);
    check("midrst_overflow", 64'(cmd_overflow), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    sck_run(20, 44, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    check("midrst_busy_late", 64'(busy), 64'd0);
    spi.spi_csb = 1'b1;
    clk_wait(8);
    check("midrst_rd_pulses", 64'(rd_cnt - rd0), 64'd1);

    frame("post_reset", 64'h7E57_0000_FFFF_1234, 0, 0, 64,
          64'h0000_0000_0055_AA55, 1, 32'h4055_AA55);

    clk_wait(20);
    check("final_cmd_queue", 64'(cmd_q.size()), 64'd0);
    check("final_miso_queue", 64'(miso_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
